// File: rtl/madd_eval_pkg.sv
// madd_eval_pkg: shared FSM state type and width helpers for the madd sweep evaluator
// Contents: state_t (IDLE/RUN/DRAIN/FIN), sum_w() = N_OUT+N_IN, cnt_w() = N_IN+1
package madd_eval_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    function automatic int sum_w(input int n_in, input int n_out);
        return n_out + n_in;
    endfunction

    function automatic int cnt_w(input int n_in);
        return n_in + 1;
    endfunction
endpackage

// File: rtl/madd_et_sweep_ctrl_if.sv
// madd_et_sweep_ctrl_if: stimulus/result bus between the sweep controller and the madd netlists
// Signals: vec_o (stimulus to both netlists), exact_i / approx_i (their results)
// Modports: master = controller side, slave = netlist side
interface madd_et_sweep_ctrl_if #(
    parameter int N_IN  = 6,
    parameter int N_OUT = 4
) ();
    logic [N_IN-1:0]  vec_o;
    logic [N_OUT-1:0] exact_i;
    logic [N_OUT-1:0] approx_i;

    modport master (output vec_o, input exact_i, input approx_i);
    modport slave  (input vec_o, output exact_i, output approx_i);
endinterface

// File: rtl/madd_err_accum.sv
// madd_err_accum: absolute-error statistics over the sampled sweep vectors
// Ports: clk, rst_n (async active-low); clear (sync restart of statistics);
//   sample_valid/sample_vec/exact/approx (one sampled vector);
//   sample_bad (current sample exceeds ET); max_err, err_sum, fail_count, first_fail_vec
module madd_err_accum
    import madd_eval_pkg::*;
#(
    parameter int N_IN  = 6,
    parameter int N_OUT = 4,
    parameter int ET    = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          sample_valid,
    input  logic [N_IN-1:0]               sample_vec,
    input  logic [N_OUT-1:0]              exact,
    input  logic [N_OUT-1:0]              approx,
    output logic                          sample_bad,
    output logic [N_OUT-1:0]              max_err,
    output logic [sum_w(N_IN, N_OUT)-1:0] err_sum,
    output logic [cnt_w(N_IN)-1:0]        fail_count,
    output logic [N_IN-1:0]               first_fail_vec
);
    localparam int SUM_W = sum_w(N_IN, N_OUT);
    localparam int CNT_W = cnt_w(N_IN);

    logic [N_OUT-1:0] e;

    assign e = exact >= approx ? exact - approx : approx - exact;
    // compared at int width so an ET beyond the output range simply never trips
    assign sample_bad = int'(e) > ET;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_err        <= '0;
            err_sum        <= '0;
            fail_count     <= '0;
            first_fail_vec <= '0;
        end else if (clear) begin
            max_err        <= '0;
            err_sum        <= '0;
            fail_count     <= '0;
            first_fail_vec <= '0;
        end else if (sample_valid) begin
            if (e > max_err) max_err <= e;
            err_sum <= err_sum + SUM_W'(e);
            if (sample_bad) begin
                fail_count <= fail_count + CNT_W'(1);
                if (fail_count == '0) first_fail_vec <= sample_vec;
            end
        end
    end
endmodule

// File: rtl/madd_et_sweep_ctrl.sv
// madd_et_sweep_ctrl: exhaustive error sweep of an approximate madd against its exact reference
// Ports: clk, rst_n (async active-low); start, abort, stop_on_fail (control);
//   dut (master): vec_o to both netlists, exact_i/approx_i back, results LAT cycles after vec_o;
//   busy, done, aborted (status); max_err, err_sum, fail_count, fail, first_fail_vec (statistics)
module madd_et_sweep_ctrl
    import madd_eval_pkg::*;
#(
    parameter int N_IN  = 6,
    parameter int N_OUT = 4,
    parameter int ET    = 5,
    parameter int LAT   = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          stop_on_fail,
    madd_et_sweep_ctrl_if.master          dut,
    output logic                          busy,
    output logic                          done,
    output logic                          aborted,
    output logic [N_OUT-1:0]              max_err,
    output logic [sum_w(N_IN, N_OUT)-1:0] err_sum,
    output logic [cnt_w(N_IN)-1:0]        fail_count,
    output logic                          fail,
    output logic [N_IN-1:0]               first_fail_vec
);
    localparam logic [N_IN-1:0] LAST = '1;

    state_t          st, nxt;
    logic [N_IN-1:0] vec_q;
    logic            stop_q, abort_q;
    logic            issue, clear, halt, flush, pipe_more;
    logic            smp_v, smp_bad;
    logic [N_IN-1:0] smp_vec;

    assign issue     = st == RUN;
    assign busy      = st == RUN || st == DRAIN;
    assign done      = st == FIN;
    assign aborted   = done && abort_q;
    assign clear     = st == IDLE && start;
    assign halt      = stop_q && smp_v && smp_bad;
    // the sample on the stopping edge is still counted; everything behind it is dropped
    assign flush     = busy && (abort || halt);
    assign dut.vec_o = vec_q;
    assign fail      = fail_count != '0;

    generate
        if (LAT == 0) begin : g_nopipe
            assign smp_v     = issue;
            assign smp_vec   = vec_q;
            assign pipe_more = 1'b0;
        end else begin : g_pipe
            logic [LAT-1:0]  pv;
            logic [N_IN-1:0] pvec [LAT];
            assign smp_v     = pv[LAT-1];
            assign smp_vec   = pvec[LAT-1];
            // anything still in flight besides the entry being sampled now
            assign pipe_more = |(pv << 1);
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pv <= '0;
                    for (int i = 0; i < LAT; i++) pvec[i] <= '0;
                end else begin
                    pv[0]   <= !flush && issue;
                    pvec[0] <= vec_q;
                    for (int i = 1; i < LAT; i++) begin
                        pv[i]   <= !flush && pv[i-1];
                        pvec[i] <= pvec[i-1];
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        nxt = st;
        case (st)
            IDLE:    nxt = start ? RUN : IDLE;
            RUN:     nxt = flush ? FIN : (vec_q != LAST) ? RUN : (LAT == 0) ? FIN : DRAIN;
            DRAIN:   nxt = (flush || !pipe_more) ? FIN : DRAIN;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= IDLE;
            vec_q   <= '0;
            stop_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            st <= nxt;
            if (clear) begin
                vec_q   <= '0;
                stop_q  <= stop_on_fail;
                abort_q <= 1'b0;
            end else begin
                if (issue && nxt == RUN) vec_q <= vec_q + N_IN'(1);
                if (busy && abort) abort_q <= 1'b1;
            end
        end
    end

    madd_err_accum #(.N_IN(N_IN), .N_OUT(N_OUT), .ET(ET)) u_accum (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (clear),
        .sample_valid  (smp_v),
        .sample_vec    (smp_vec),
        .exact         (dut.exact_i),
        .approx        (dut.approx_i),
        .sample_bad    (smp_bad),
        .max_err       (max_err),
        .err_sum       (err_sum),
        .fail_count    (fail_count),
        .first_fail_vec(first_fail_vec)
    );
endmodule

// File: tb/tb_madd_et_sweep_ctrl.sv
// tb_madd_et_sweep_ctrl: randomized sweeps of LAT=0 and LAT=2 controllers against a behavioural model
module tb_madd_et_sweep_ctrl;
    localparam int N_IN = 6, N_OUT = 4, ET = 5, NV = 64;

    logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, abort = 1'b0, stop_on_fail = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] ex_tab [NV];
    logic [3:0] ap_tab [NV];

    madd_et_sweep_ctrl_if #(.N_IN(N_IN), .N_OUT(N_OUT)) if0 ();
    madd_et_sweep_ctrl_if #(.N_IN(N_IN), .N_OUT(N_OUT)) if2 ();

    logic       busy0, done0, ab0, fl0, busy2, done2, ab2, fl2;
    logic [3:0] mx0, mx2;
    logic [9:0] sum0, sum2;
    logic [6:0] fc0, fc2;
    logic [5:0] ffv0, ffv2;
    logic [5:0] d1 = '0, d2 = '0;

    always @(posedge clk) begin
        d1 <= if2.vec_o;
        d2 <= d1;
    end
    assign if0.exact_i  = ex_tab[if0.vec_o];
    assign if0.approx_i = ap_tab[if0.vec_o];
    assign if2.exact_i  = ex_tab[d2];
    assign if2.approx_i = ap_tab[d2];

    madd_et_sweep_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .ET(ET), .LAT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stop_on_fail(stop_on_fail),
        .dut(if0), .busy(busy0), .done(done0), .aborted(ab0), .max_err(mx0), .err_sum(sum0),
        .fail_count(fc0), .fail(fl0), .first_fail_vec(ffv0));
    madd_et_sweep_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .ET(ET), .LAT(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stop_on_fail(stop_on_fail),
        .dut(if2), .busy(busy2), .done(done2), .aborted(ab2), .max_err(mx2), .err_sum(sum2),
        .fail_count(fc2), .fail(fl2), .first_fail_vec(ffv2));

    int n_cmp = 0, n_bad = 0;

    function automatic void chk(string nm, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    // d: period (1 = first cycle after the start edge) in which done is high
    typedef struct {int d; bit ab; int mx; int sum; int fc; int ffv;} res_t;

    // vector v is sampled at the end of period v+1+lat; a stop ends the sweep right after
    // the first failing sample, an abort right after the period it is held in
    function automatic res_t model(int lat, bit stp, int a);
        res_t r;
        int fp, e;
        r = '{default: 0};
        fp = 0;
        for (int v = 0; v < NV; v++) begin
            e = int'(ex_tab[v]) - int'(ap_tab[v]);
            if (e < 0) e = -e;
            if (stp && e > ET && fp == 0) fp = v + 1 + lat;
        end
        r.d = fp != 0 ? fp + 1 : NV + lat + 1;
        if (a > 0 && a < r.d) begin
            r.d  = a + 1;
            r.ab = 1'b1;
        end
        for (int v = 0; v < NV; v++) begin
            e = int'(ex_tab[v]) - int'(ap_tab[v]);
            if (e < 0) e = -e;
            if (v + 1 + lat < r.d) begin
                if (e > r.mx) r.mx = e;
                r.sum += e;
                if (e > ET) begin
                    if (r.fc == 0) r.ffv = v;
                    r.fc++;
                end
            end
        end
        return r;
    endfunction

    res_t m0, m2;
    bit   track = 1'b0;
    int   per = 0;

    function automatic void cmp(int k, res_t m, int p, logic b, logic dn, logic ab, logic [5:0] v,
                                logic [3:0] mx, logic [9:0] sm, logic [6:0] fc, logic fl,
                                logic [5:0] ffv);
        string t = $sformatf("lat%0d p%0d", k, p);
        chk({t, " busy"}, b, p < m.d);
        chk({t, " done"}, dn, p == m.d);
        chk({t, " aborted"}, ab, p == m.d && m.ab);
        if (p <= NV && p < m.d) chk({t, " vec_o"}, v, p - 1);
        if (p >= m.d) begin
            chk({t, " max_err"}, mx, m.mx);
            chk({t, " err_sum"}, sm, m.sum);
            chk({t, " fail_count"}, fc, m.fc);
            chk({t, " fail"}, fl, m.fc != 0);
            chk({t, " first_fail_vec"}, ffv, m.ffv);
        end
    endfunction

    always @(posedge clk) begin
        #1;
        if (track) begin
            per++;
            cmp(0, m0, per, busy0, done0, ab0, if0.vec_o, mx0, sum0, fc0, fl0, ffv0);
            cmp(2, m2, per, busy2, done2, ab2, if2.vec_o, mx2, sum2, fc2, fl2, ffv2);
            if (per > (m0.d > m2.d ? m0.d : m2.d)) track = 1'b0;
        end
    end

    // mode 0: exact==approx, 1: approx=0, 2: random; ab_q: abort period (0 none);
    // sp_q: period of an ignored start pulse (-1 random, 0 none)
    task automatic sweep(input int mode, input bit stp, input int ab_q, input int sp_q_in);
        int sp_q, mind;
        for (int v = 0; v < NV; v++) begin
            ex_tab[v] = mode == 2 ? 4'($urandom) : 4'(v);
            ap_tab[v] = mode == 0 ? 4'(v) : mode == 1 ? 4'd0 : ex_tab[v] + 4'($urandom_range(0, 7));
        end
        m0 = model(0, stp, ab_q);
        m2 = model(2, stp, ab_q);
        mind = m0.d < m2.d ? m0.d : m2.d;
        sp_q = sp_q_in >= 0 ? sp_q_in : mind > 3 ? int'($urandom_range(2, mind - 1)) : 0;
        @(negedge clk);
        start = 1'b1;
        stop_on_fail = stp;
        per = 0;
        track = 1'b1;
        for (int q = 1; track && q < 300; q++) begin
            @(negedge clk);
            start = q == sp_q;
            abort = q == ab_q;
            stop_on_fail = 1'($urandom);
        end
        start = 1'b0;
        abort = 1'b0;
        chk("sweep completes", track, 0);
        track = 1'b0;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst busy", busy0 | busy2, 0);
        chk("rst done", done0 | done2, 0);
        chk("rst aborted", ab0 | ab2, 0);
        chk("rst vec_o", {if0.vec_o, if2.vec_o}, 0);
        chk("rst stats", {mx0, sum0, fc0, fl0, ffv0, mx2, sum2, fc2, fl2, ffv2}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("idle abort busy", busy0 | busy2, 0);
        chk("idle abort done", done0 | done2, 0);

        sweep(0, 0, 0, -1);
        chk("pin clean d", m0.d, 65);
        chk("pin clean d lat2", m2.d, 67);
        chk("pin clean fc", m0.fc, 0);

        sweep(1, 0, 0, -1);
        chk("pin ramp max", m0.mx, 15);
        chk("pin ramp sum", m0.sum, 480);
        chk("pin ramp fc", m0.fc, 40);
        chk("pin ramp ffv", m0.ffv, 6);
        chk("pin ramp lat2 sum", m2.sum, 480);

        sweep(1, 1, 0, -1);
        chk("pin stop d", m0.d, 8);
        chk("pin stop sum", m0.sum, 21);
        chk("pin stop fc", m0.fc, 1);
        chk("pin stop lat2 d", m2.d, 10);

        sweep(1, 0, 11, 5);
        chk("pin abort d", m0.d, 12);
        chk("pin abort sum", m0.sum, 55);
        chk("pin abort fc", m0.fc, 5);
        chk("pin abort lat2 sum", m2.sum, 36);

        sweep(1, 0, 64, -1);
        chk("pin abort last ab", m0.ab, 1);
        chk("pin abort last sum", m0.sum, 480);

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        chk("pre-reset vec_o", if0.vec_o, 30);
        chk("pre-reset vec_o lat2", if2.vec_o, 30);
        rst_n = 1'b0;
        #1;
        chk("mid rst busy", busy0 | busy2, 0);
        chk("mid rst vec_o", {if0.vec_o, if2.vec_o}, 0);
        chk("mid rst stats", {mx0, sum0, fc0, fl0, ffv0, mx2, sum2, fc2, fl2, ffv2}, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid rst no done", done0 | done2, 0);
        end
        rst_n = 1'b1;
        sweep(1, 0, 0, -1);
        chk("pin post-reset d", m0.d, 65);

        for (int i = 0; i < 6; i++)
            sweep(2, 1'($urandom), ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 70)) : 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
